axis_ascon_release_gate: RTL and testbench
==========================================

Name: axis_ascon_release_gate

Overview:
- Sits directly downstream of axis_ascon_aead128 in decrypt mode.
- Buffers one complete decrypted plaintext message, then consumes the core's tag-compare output; an all-zero tag means authentication passed.
- Releases the buffered plaintext only on pass, and silently discards it on fail or buffer overflow.
- Emits one status word per message so that unauthenticated plaintext never leaves the crypto boundary.

Parameters:
- aw, 4: log2 of buffer depth in beats; depth = 2**aw.
- keep_support, 1: 1 = store and forward tkeep; 0 = tkeep not stored and m_tkeep driven all ones.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- s_tvalid  in  1  plaintext beat valid (from core m_tvalid)
- s_tready  out  1  plaintext ready
- s_tlast  in  1  last beat of message
- s_tdata  in  128  plaintext data
- s_tkeep  in  16  byte enables
- s_tag_tvalid  in  1  tag-compare result valid (from core m_tag_tvalid)
- s_tag_tready  out  1  tag-compare ready
- s_tag_tdata  in  128  tag XOR; zero = authentic
- m_tvalid  out  1  released plaintext valid
- m_tready  in  1  downstream ready
- m_tlast  out  1  last beat
- m_tdata  out  128  released plaintext
- m_tkeep  out  16  byte enables
- m_status_tvalid  out  1  per-message status valid
- m_status_tready  in  1  status ready
- m_status_tdata  out  2  01 = PASS, 10 = FAIL, 11 = OVERFLOW

Behaviour:
- Reset (asynchronous, resetn low) at any time, including mid-message:
  - state = FILL; buffer pointers and count = 0; ovf flag = 0.
  - m_tvalid = 0, m_status_tvalid = 0, s_tag_tready = 0, s_tready = 0 while resetn is low.
  - Buffered data is lost and no status is emitted for the interrupted message.
- Buffer: 2**aw entries of {tlast, tdata, tkeep}. Combinational read of head entry. Single-cycle clear. Count width aw+1.
- FILL:
  - s_tready = !full. Each s handshake writes one entry.
  - Handshake with s_tlast -> WAIT_TAG.
  - full && last written entry has no tlast -> OVERFLOW on the next edge, clearing the buffer and setting ovf.
  - A message of exactly 2**aw beats ending in tlast fits and is not an overflow.
- OVERFLOW: s_tready = 1; beats are dropped. Handshake with s_tlast -> WAIT_TAG.
- WAIT_TAG:
  - s_tready = 0, s_tag_tready = 1.
  - On tag handshake: ovf -> STATUS with code 11 and buffer cleared; tag == 0 -> RELEASE; otherwise -> DROP.
  - A tag arriving before WAIT_TAG stalls; s_tag_tready stays 0 in every other state.
- RELEASE:
  - m_tvalid = !empty, driven from head entry; pop on m handshake. Throughput 1 beat per clock.
  - First m_tvalid is in the cycle after the tag handshake.
  - Pop of the entry with tlast -> STATUS with code 01.
- DROP: buffer cleared in 1 cycle -> STATUS with code 10.
- STATUS:
  - m_status_tvalid = 1 with the code held stable.
  - On handshake -> FILL and ovf cleared. s_tready = 0 in this state.
- Ordering:
  - For PASS, the status is emitted strictly after the last plaintext beat.
  - At most one message is in flight; the next message's beats are not accepted until status is taken.
- m_tdata, m_tkeep and m_tlast are don't-care when m_tvalid = 0.
- A beat with tkeep = 0 (empty-plaintext message) is stored and forwarded unchanged.
- keep_support = 0: the tkeep column is not stored and m_tkeep = 16'hffff.
- All handshakes follow AXI-Stream rules: valid does not depend on ready, and payload is stable while valid && !ready.

Decomposition:
- Package ascon_pkg:
  - constants ASCON_STATUS_PASS/FAIL/OVERFLOW (2 bits)
  - data width 128, keep width 16
  - state encoding typedef for FILL/OVERFLOW/WAIT_TAG/RELEASE/DROP/STATUS
- Sub-module ascon_beat_buffer:
  - synchronous FIFO with push, pop, clear, full, empty and combinational head.
  - Parameters aw and dw (dw = 145, or 129 without keep).

Test Plan:
- 3-beat message, last tkeep = 16'h00ff, tag 0, m_tready = 1 -> 3 beats out identical in order, m_tlast on beat 3, then status 01.
- 2-beat message, tag = 128'h1 -> no m_tvalid ever asserted, status 10, next message accepted afterwards.
- aw = 2: 5-beat message with tag 0 -> all 5 input beats accepted, no output beats, status 11, tag consumed.
- aw = 2: 4-beat message ending in tlast, tag 0 -> 4 beats released, status 01 (full boundary is not an overflow).
- Tag presented before the message's first beat, random m_tready and m_status_tready -> tag held unaccepted until WAIT_TAG; data matches; status after last beat.
- resetn pulsed low during RELEASE after 1 of 3 beats -> m_tvalid drops immediately; fresh message afterwards passes with status 01.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared constants and types for the Ascon decrypt release gate.
package ascon_pkg;

    localparam int unsigned ASCON_DATA_W = 128;
    localparam int unsigned ASCON_KEEP_W = 16;

    localparam logic [1:0] ASCON_STATUS_PASS     = 2'b01;
    localparam logic [1:0] ASCON_STATUS_FAIL     = 2'b10;
    localparam logic [1:0] ASCON_STATUS_OVERFLOW = 2'b11;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_OVERFLOW,
        ST_WAIT_TAG,
        ST_RELEASE,
        ST_DROP,
        ST_STATUS
    } gate_state_e;

    // Width of one buffered entry: {tlast, tdata[, tkeep]}.
    function automatic int unsigned beat_width(input int unsigned keep_support);
        return 1 + ASCON_DATA_W + ((keep_support != 0) ? ASCON_KEEP_W : 0);
    endfunction

endpackage

// File: rtl/ascon_beat_buffer.sv
// Single-clock FIFO holding one plaintext message; combinational head,
// single-cycle clear that takes priority over push and pop.
module ascon_beat_buffer #(
    parameter int unsigned aw = 4,
    parameter int unsigned dw = 145
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [dw-1:0] wdata_i,
    input  logic          pop_i,
    input  logic          clear_i,
    output logic [dw-1:0] head_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned DEPTH = 2 ** aw;

    logic [dw-1:0] mem_q [DEPTH];
    logic [aw-1:0] wr_ptr_q, wr_ptr_d;
    logic [aw-1:0] rd_ptr_q, rd_ptr_d;
    logic [aw:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (aw + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/axis_ascon_release_gate.sv
// Holds one decrypted message until its tag-compare result arrives, then
// releases it on pass or discards it on fail/overflow, with one status word
// per message.
module axis_ascon_release_gate
    import ascon_pkg::*;
#(
    parameter int unsigned aw           = 4,
    parameter int unsigned keep_support = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic                    s_tlast,
    input  logic [ASCON_DATA_W-1:0] s_tdata,
    input  logic [ASCON_KEEP_W-1:0] s_tkeep,
    input  logic                    s_tag_tvalid,
    output logic                    s_tag_tready,
    input  logic [ASCON_DATA_W-1:0] s_tag_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic [ASCON_DATA_W-1:0] m_tdata,
    output logic [ASCON_KEEP_W-1:0] m_tkeep,
    output logic                    m_status_tvalid,
    input  logic                    m_status_tready,
    output logic [1:0]              m_status_tdata
);

    localparam int unsigned DW = beat_width(keep_support);

    gate_state_e state_q;
    logic        ovf_q;
    logic [1:0]  status_q;
    logic        run_q;   // holds s_tready low until the first edge after reset

    logic          buf_push, buf_pop, buf_clear, buf_full, buf_empty;
    logic [DW-1:0] wr_entry, head_entry;
    logic          tag_hs, s_hs;

    if (keep_support != 0) begin : g_keep
        assign wr_entry = {s_tlast, s_tdata, s_tkeep};
        assign m_tkeep  = head_entry[ASCON_KEEP_W-1:0];
    end else begin : g_nokeep
        assign wr_entry = {s_tlast, s_tdata};
        assign m_tkeep  = '1;
    end

    assign m_tlast = head_entry[DW-1];
    assign m_tdata = head_entry[DW-2 -: ASCON_DATA_W];

    ascon_beat_buffer #(
        .aw (aw),
        .dw (DW)
    ) u_buffer (
        .clk_i   (clk),
        .rst_ni  (resetn),
        .push_i  (buf_push),
        .wdata_i (wr_entry),
        .pop_i   (buf_pop),
        .clear_i (buf_clear),
        .head_o  (head_entry),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    // Handshake and buffer control decoded from the current state.
    always_comb begin
        s_tready        = 1'b0;
        s_tag_tready    = 1'b0;
        m_tvalid        = 1'b0;
        m_status_tvalid = 1'b0;
        m_status_tdata  = status_q;
        buf_push        = 1'b0;
        buf_pop         = 1'b0;
        buf_clear       = 1'b0;
        case (state_q)
            ST_FILL: begin
                s_tready  = run_q && !buf_full;
                buf_push  = s_tvalid && s_tready;
                buf_clear = buf_full;
            end
            ST_OVERFLOW: s_tready = 1'b1;
            ST_WAIT_TAG: begin
                s_tag_tready = 1'b1;
                buf_clear    = s_tag_tvalid && ovf_q;
            end
            ST_RELEASE: begin
                m_tvalid = !buf_empty;
                buf_pop  = m_tvalid && m_tready;
            end
            ST_DROP:   buf_clear = 1'b1;
            ST_STATUS: m_status_tvalid = 1'b1;
            default: ;
        endcase
    end

    assign s_hs   = s_tvalid && s_tready;
    assign tag_hs = s_tag_tvalid && s_tag_tready;

    // Message sequencing: fill, await tag, release or discard, report status.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_FILL;
            ovf_q    <= 1'b0;
            status_q <= '0;
            run_q    <= 1'b0;
        end else begin
            run_q <= 1'b1;
            case (state_q)
                ST_FILL: begin
                    // Reaching full while still in FILL means the newest entry lacked tlast.
                    if (buf_full) begin
                        state_q <= ST_OVERFLOW;
                        ovf_q   <= 1'b1;
                    end else if (s_hs && s_tlast) begin
                        state_q <= ST_WAIT_TAG;
                    end
                end
                ST_OVERFLOW: begin
                    if (s_hs && s_tlast) state_q <= ST_WAIT_TAG;
                end
                ST_WAIT_TAG: begin
                    if (tag_hs) begin
                        if (ovf_q) begin
                            state_q  <= ST_STATUS;
                            status_q <= ASCON_STATUS_OVERFLOW;
                        end else if (s_tag_tdata == '0) begin
                            state_q <= ST_RELEASE;
                        end else begin
                            state_q <= ST_DROP;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (buf_pop && m_tlast) begin
                        state_q  <= ST_STATUS;
                        status_q <= ASCON_STATUS_PASS;
                    end
                end
                ST_DROP: begin
                    state_q  <= ST_STATUS;
                    status_q <= ASCON_STATUS_FAIL;
                end
                ST_STATUS: begin
                    if (m_status_tready) begin
                        state_q <= ST_FILL;
                        ovf_q   <= 1'b0;
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_ascon_release_gate.sv
// Scoreboard bench for axis_ascon_release_gate with a 4-deep buffer.
module tb_axis_ascon_release_gate;
    import ascon_pkg::*;

    localparam int unsigned AW = 2;

    typedef struct packed {
        logic         last;
        logic [127:0] data;
        logic [15:0]  keep;
    } beat_t;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         s_tvalid, s_tready, s_tlast;
    logic [127:0] s_tdata;
    logic [15:0]  s_tkeep;
    logic         s_tag_tvalid, s_tag_tready;
    logic [127:0] s_tag_tdata;
    logic         m_tvalid, m_tready, m_tlast;
    logic [127:0] m_tdata;
    logic [15:0]  m_tkeep;
    logic         m_status_tvalid, m_status_tready;
    logic [1:0]   m_status_tdata;

    beat_t      exp_beats[$];
    logic [1:0] exp_status[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         rdy_mode = 0;   // 0: always ready, 1: random, 2: driven by main thread
    int         st_mode = 0;

    axis_ascon_release_gate #(
        .aw           (AW),
        .keep_support (1)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .s_tvalid        (s_tvalid),
        .s_tready        (s_tready),
        .s_tlast         (s_tlast),
        .s_tdata         (s_tdata),
        .s_tkeep         (s_tkeep),
        .s_tag_tvalid    (s_tag_tvalid),
        .s_tag_tready    (s_tag_tready),
        .s_tag_tdata     (s_tag_tdata),
        .m_tvalid        (m_tvalid),
        .m_tready        (m_tready),
        .m_tlast         (m_tlast),
        .m_tdata         (m_tdata),
        .m_tkeep         (m_tkeep),
        .m_status_tvalid (m_status_tvalid),
        .m_status_tready (m_status_tready),
        .m_status_tdata  (m_status_tdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Output monitor: a transfer seen at the falling edge completes at the next rising edge.
    always @(negedge clk) begin
        beat_t      b;
        logic [1:0] code;
        if (m_tvalid && m_tready) begin
            if (exp_beats.size() == 0) begin
                check_eq("beat_unexpected", m_tvalid, 0);
            end else begin
                b = exp_beats.pop_front();
                check_eq("m_tdata", m_tdata, b.data);
                check_eq("m_tkeep", m_tkeep, b.keep);
                check_eq("m_tlast", m_tlast, b.last);
            end
        end
        if (m_status_tvalid && m_status_tready) begin
            if (exp_status.size() == 0) begin
                check_eq("status_unexpected", m_status_tvalid, 0);
            end else begin
                code = exp_status.pop_front();
                check_eq("status", m_status_tdata, code);
                if (code == ASCON_STATUS_PASS) check_eq("pass_after_last", exp_beats.size(), 0);
            end
        end
    end

    // Downstream ready generators.
    initial begin
        m_tready = 1'b1;
        m_status_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) m_tready = 1'b1;
            else if (rdy_mode == 1) m_tready = 1'($urandom_range(0, 1));
            if (st_mode == 0) m_status_tready = 1'b1;
            else m_status_tready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_beat(input beat_t b, output bit ok);
        s_tvalid = 1'b1;
        s_tdata  = b.data;
        s_tkeep  = b.keep;
        s_tlast  = b.last;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (s_tready) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_tag(input logic [127:0] tag);
        bit ok = 1'b0;
        s_tag_tvalid = 1'b1;
        s_tag_tdata  = tag;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (s_tag_tready) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        s_tag_tvalid = 1'b0;
        check_eq("tag_accepted", ok, 1);
    endtask

    task automatic send_beats(input beat_t beats[$]);
        int acc = 0;
        bit ok;
        foreach (beats[i]) begin
            send_beat(beats[i], ok);
            if (ok) acc++;
        end
        check_eq("beats_accepted", acc, beats.size());
    endtask

    task automatic make_msg(input int n, input logic [15:0] last_keep, output beat_t beats[$]);
        beat_t b;
        beats = {};
        for (int i = 0; i < n; i++) begin
            b.data = {$urandom(), $urandom(), $urandom(), $urandom()};
            b.keep = (i == n - 1) ? last_keep : 16'hffff;
            b.last = (i == n - 1);
            beats.push_back(b);
        end
    endtask

    task automatic wait_drain();
        int c = 0;
        while ((exp_beats.size() != 0 || exp_status.size() != 0) && c < 1000) begin
            @(posedge clk);
            c++;
        end
        check_eq("drained", exp_beats.size() + exp_status.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_msg(input int n, input logic [15:0] last_keep, input logic [127:0] tag,
                            input logic [1:0] code, input bit early_tag);
        beat_t   beats[$];
        realtime tag_t, last_t;
        make_msg(n, last_keep, beats);
        if (code == ASCON_STATUS_PASS) foreach (beats[i]) exp_beats.push_back(beats[i]);
        exp_status.push_back(code);
        if (early_tag) begin
            fork
                begin send_tag(tag); tag_t = $realtime; end
                begin send_beats(beats); last_t = $realtime; end
            join
            check_eq("tag_after_last", tag_t > last_t, 1);
        end else begin
            send_beats(beats);
            send_tag(tag);
            check_eq("m_tvalid_after_tag", m_tvalid, code == ASCON_STATUS_PASS);
        end
        wait_drain();
    endtask

    task automatic reset_mid_release();
        beat_t beats[$];
        rdy_mode = 2;
        @(posedge clk);
        #1;
        m_tready = 1'b0;
        make_msg(3, 16'hffff, beats);
        exp_beats.push_back(beats[0]);
        send_beats(beats);
        send_tag('0);
        check_eq("rst_pre_tvalid", m_tvalid, 1);
        m_tready = 1'b1;
        @(posedge clk);
        #1;
        m_tready = 1'b0;
        check_eq("rst_one_popped", exp_beats.size(), 0);
        check_eq("rst_second_pending", m_tvalid, 1);
        #2 resetn = 1'b0;
        #1;
        check_eq("rst_m_tvalid", m_tvalid, 0);
        check_eq("rst_s_tready", s_tready, 0);
        check_eq("rst_tag_tready", s_tag_tready, 0);
        check_eq("rst_status_tvalid", m_status_tvalid, 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        rdy_mode = 0;
        repeat (8) @(posedge clk);
        #1;
        check_eq("post_rst_no_status", m_status_tvalid, 0);
        check_eq("post_rst_no_tvalid", m_tvalid, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        s_tdata = '0;
        s_tkeep = '0;
        s_tag_tvalid = 1'b0;
        s_tag_tdata = '0;
        #2;
        check_eq("reset_s_tready", s_tready, 0);
        check_eq("reset_m_tvalid", m_tvalid, 0);
        check_eq("reset_tag_tready", s_tag_tready, 0);
        check_eq("reset_status_tvalid", m_status_tvalid, 0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        send_msg(3, 16'h00ff, '0, ASCON_STATUS_PASS, 1'b0);
        send_msg(2, 16'hffff, 128'h1, ASCON_STATUS_FAIL, 1'b0);
        send_msg(5, 16'hffff, '0, ASCON_STATUS_OVERFLOW, 1'b0);
        send_msg(4, 16'hffff, '0, ASCON_STATUS_PASS, 1'b0);
        rdy_mode = 1;
        st_mode = 1;
        send_msg(3, 16'h0f0f, '0, ASCON_STATUS_PASS, 1'b1);
        rdy_mode = 0;
        st_mode = 0;
        send_msg(1, 16'h0000, '0, ASCON_STATUS_PASS, 1'b0);
        reset_mid_release();
        send_msg(2, 16'h7fff, '0, ASCON_STATUS_PASS, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
